// File: rtl/branch_resolve_bht_pkg.sv
// Shared opcode/rt constants and condition decode for branch resolution.
package branch_resolve_bht_pkg;

  localparam logic [5:0]  OP_REGIMM = 6'b000001;
  localparam logic [5:0]  OP_BEQ    = 6'b000100;
  localparam logic [5:0]  OP_BNE    = 6'b000101;
  localparam logic [5:0]  OP_BLEZ   = 6'b000110;
  localparam logic [5:0]  OP_BGTZ   = 6'b000111;

  localparam logic [4:0]  RT_BLTZ   = 5'b00000;
  localparam logic [4:0]  RT_BGEZ   = 5'b00001;
  localparam logic [4:0]  RT_BLTZAL = 5'b10000;
  localparam logic [4:0]  RT_BGEZAL = 5'b10001;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [2:0] {
    COND_NONE,
    COND_EQ,
    COND_NE,
    COND_LEZ,
    COND_GTZ,
    COND_LTZ,
    COND_GEZ
  } cond_e;

  // Map op/rt to the comparison the branch needs; non-branches give COND_NONE.
  function automatic cond_e decode_cond(input logic [5:0] op, input logic [4:0] rt);
    cond_e c;
    c = COND_NONE;
    case (op)
      OP_BEQ:  c = COND_EQ;
      OP_BNE:  c = COND_NE;
      OP_BLEZ: c = COND_LEZ;
      OP_BGTZ: c = COND_GTZ;
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BLTZAL: c = COND_LTZ;
          RT_BGEZ, RT_BGEZAL: c = COND_GEZ;
          default:            c = COND_NONE;
        endcase
      end
      default: c = COND_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter, one per predictor table entry.
module sat_counter2 #(
  parameter logic [1:0] INIT = 2'b01
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_inc,
  output logic [1:0] o_cnt
);

  logic [1:0] r_cnt;

  // Step toward 3 on taken, toward 0 on not-taken, clamping at the ends.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= INIT;
    end else if (i_en) begin
      if (i_inc) begin
        if (r_cnt != 2'b11) r_cnt <= r_cnt + 2'b01;
      end else begin
        if (r_cnt != 2'b00) r_cnt <= r_cnt - 2'b01;
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_resolve_bht.sv
// ID-stage branch resolution with a direct-mapped 2-bit predictor table,
// registered mispredict/redirect pulse and saturating statistics.
module branch_resolve_bht
  import branch_resolve_bht_pkg::*;
#(
  parameter int         DATA_W   = 32,
  parameter int         PC_W     = 32,
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int         STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   f_pc,
  output logic              f_pred_taken,
  input  logic              r_valid,
  input  logic              r_stall,
  input  logic [5:0]        r_op,
  input  logic [4:0]        r_rt,
  input  logic [PC_W-1:0]   r_pc,
  input  logic [DATA_W-1:0] r_src_a,
  input  logic [DATA_W-1:0] r_src_b,
  input  logic              r_pred_taken,
  output logic              r_is_branch,
  output logic              r_taken,
  output logic              mispredict,
  output logic              redirect_taken,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispredict_cnt
);

  localparam int N_ENT = 1 << IDX_W;

  cond_e              w_cond;
  logic               w_a_zero;
  logic               w_a_neg;
  logic               w_res;
  logic               w_mis_cond;
  logic [IDX_W-1:0]   w_f_idx;
  logic [IDX_W-1:0]   w_r_idx;
  logic [1:0]         w_cnt [N_ENT];
  logic [N_ENT-1:0]   w_cnt_lsb_unused;
  logic               w_pc_unused;

  logic               r_mispredict;
  logic               r_redirect_taken;
  logic [STAT_W-1:0]  r_branch_cnt;
  logic [STAT_W-1:0]  r_mispredict_cnt;

  assign w_f_idx = f_pc[IDX_W+1:2];
  assign w_r_idx = r_pc[IDX_W+1:2];
  assign w_pc_unused = ^{f_pc[PC_W-1:IDX_W+2], f_pc[1:0], r_pc[PC_W-1:IDX_W+2], r_pc[1:0]};

  // Decode the branch kind and evaluate its condition on the forwarded operands.
  always_comb begin
    w_cond      = decode_cond(r_op, r_rt);
    w_a_zero    = (r_src_a == '0);
    w_a_neg     = r_src_a[DATA_W-1];
    r_is_branch = (w_cond != COND_NONE);
    r_taken     = 1'b0;
    case (w_cond)
      COND_EQ:  r_taken = (r_src_a == r_src_b);
      COND_NE:  r_taken = (r_src_a != r_src_b);
      COND_LEZ: r_taken = w_a_zero | w_a_neg;
      COND_GTZ: r_taken = ~w_a_zero & ~w_a_neg;
      COND_LTZ: r_taken = w_a_neg;
      COND_GEZ: r_taken = ~w_a_neg;
      default:  r_taken = 1'b0;
    endcase
  end

  assign w_res      = r_valid & ~r_stall & r_is_branch;
  assign w_mis_cond = w_res & (r_taken != r_pred_taken);

  // One counter per entry; only the entry addressed by the resolving PC trains.
  for (genvar gi = 0; gi < N_ENT; gi++) begin : g_entry
    sat_counter2 #(.INIT(CNT_INIT)) u_ctr (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (w_res && (w_r_idx == IDX_W'(gi))),
      .i_inc (r_taken),
      .o_cnt (w_cnt[gi])
    );
    assign w_cnt_lsb_unused[gi] = w_cnt[gi][0];
  end

  // Reads the pre-update value on a same-index collision; no bypass by design.
  assign f_pred_taken = w_cnt[w_f_idx][1];

  // Mispredict pulse; redirect direction is kept until the next mispredict.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mispredict     <= 1'b0;
      r_redirect_taken <= 1'b0;
    end else begin
      r_mispredict <= w_mis_cond;
      if (w_mis_cond) r_redirect_taken <= r_taken;
    end
  end

  // Statistics stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (w_res && !(&r_branch_cnt))          r_branch_cnt     <= r_branch_cnt + STAT_W'(1);
      if (w_mis_cond && !(&r_mispredict_cnt)) r_mispredict_cnt <= r_mispredict_cnt + STAT_W'(1);
    end
  end

  assign mispredict     = r_mispredict;
  assign redirect_taken = r_redirect_taken;
  assign branch_cnt     = r_branch_cnt;
  assign mispredict_cnt = r_mispredict_cnt;

endmodule
